pixel_stream_unpacker: RTL and testbench

Sits directly downstream of the pixel array top level. Captures each parallel readout word presented on DATA_OUT, qualified by DATA_OUT_CLK, into a small word FIFO. Unpacks each word into a one-pixel-per-cycle valid/ready stream tagged with x/y coordinates and frame markers. Everything runs on SYSTEM_CLK; DATA_OUT_CLK is treated as a strobe level and edge-detected, never used as a clock.

---
 rtl/pixel_stream_unpacker.sv | 146 ++++++++++++++
 tb/tb_pixel_stream_unpacker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_unpacker.sv
// Captures strobed readout words into a small FIFO and replays them as a
// one-pixel-per-cycle valid/ready stream tagged with x/y and frame markers.
module pixel_stream_unpacker #(
  parameter int WIDTH                  = 100,
  parameter int HEIGHT                 = 100,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 10,
  parameter int BIT_DEPTH              = 10,
  parameter int FIFO_DEPTH             = 4
) (
  input  logic                                        SYSTEM_CLK,
  input  logic                                        SYSTEM_RESET,
  input  logic                                        DATA_OUT_CLK,
  input  logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0] DATA_OUT,
  output logic [BIT_DEPTH-1:0]                        PIXEL_OUT,
  output logic                                        PIXEL_VALID,
  input  logic                                        PIXEL_READY,
  output logic [$clog2(WIDTH)-1:0]                    PIXEL_X,
  output logic [$clog2(HEIGHT)-1:0]                   PIXEL_Y,
  output logic                                        FRAME_START,
  output logic                                        FRAME_END,
  output logic                                        OVERFLOW
);

  localparam int BUS_W = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
  localparam int WPR   = WIDTH / OUTPUT_BUS_PIXEL_WIDTH;
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int CW    = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int LW    = (OUTPUT_BUS_PIXEL_WIDTH > 1) ? $clog2(OUTPUT_BUS_PIXEL_WIDTH) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int EW    = YW + CW + BUS_W;

  typedef enum logic {IDLE, EMIT} state_t;

  logic [EW-1:0]    r_mem [FIFO_DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             r_dclk_q;
  logic [CW-1:0]    r_wr_col;
  logic [YW-1:0]    r_wr_row;
  state_t           r_state;
  logic [BUS_W-1:0] r_word;
  logic [LW-1:0]    r_lane;
  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;
  logic             r_overflow;

  logic             w_strobe;
  logic             w_empty;
  logic             w_full;
  logic             w_hs;
  logic             w_last;
  logic             w_pop;
  logic             w_push;
  logic [EW-1:0]    w_rd_entry;
  logic [BUS_W-1:0] w_rd_word;
  logic [CW-1:0]    w_rd_col;
  logic [YW-1:0]    w_rd_row;
  logic [XW-1:0]    w_rd_x;

  assign w_strobe = DATA_OUT_CLK & ~r_dclk_q;
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_hs     = (r_state == EMIT) && PIXEL_READY;
  assign w_last   = (r_lane == LW'(OUTPUT_BUS_PIXEL_WIDTH - 1));
  assign w_pop    = !w_empty && ((r_state == IDLE) || (w_hs && w_last));
  // A pop in the same cycle frees a slot, so a strobe into a full FIFO still lands.
  assign w_push   = w_strobe && (!w_full || w_pop);

  assign w_rd_entry                      = r_mem[r_rptr[PW-1:0]];
  assign {w_rd_row, w_rd_col, w_rd_word} = w_rd_entry;
  assign w_rd_x                          = XW'(w_rd_col) * XW'(OUTPUT_BUS_PIXEL_WIDTH);

  always_ff @(posedge SYSTEM_CLK) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= {r_wr_row, r_wr_col, DATA_OUT};
  end

  // Word index is tracked as a (row, column) pair so the read side needs no divider.
  always_ff @(posedge SYSTEM_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      r_dclk_q   <= 1'b1;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_wr_col   <= '0;
      r_wr_row   <= '0;
      r_state    <= IDLE;
      r_word     <= '0;
      r_lane     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_dclk_q <= DATA_OUT_CLK;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_strobe && w_full && !w_pop) r_overflow <= 1'b1;

      if (w_strobe) begin
        if (r_wr_col == CW'(WPR - 1)) begin
          r_wr_col <= '0;
          r_wr_row <= (r_wr_row == YW'(HEIGHT - 1)) ? '0 : r_wr_row + 1'b1;
        end else begin
          r_wr_col <= r_wr_col + 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_word  <= w_rd_word;
            r_lane  <= '0;
            r_x     <= w_rd_x;
            r_y     <= w_rd_row;
            r_state <= EMIT;
          end
        end
        EMIT: begin
          if (PIXEL_READY) begin
            if (!w_last) begin
              r_word <= r_word >> BIT_DEPTH;
              r_lane <= r_lane + 1'b1;
              r_x    <= r_x + 1'b1;
            end else if (!w_empty) begin
              r_word <= w_rd_word;
              r_lane <= '0;
              r_x    <= w_rd_x;
              r_y    <= w_rd_row;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign PIXEL_OUT   = r_word[BIT_DEPTH-1:0];
  assign PIXEL_VALID = (r_state == EMIT);
  assign PIXEL_X     = r_x;
  assign PIXEL_Y     = r_y;
  assign FRAME_START = (r_state == EMIT) && (r_x == '0) && (r_y == '0);
  assign FRAME_END   = (r_state == EMIT) && (r_x == XW'(WIDTH - 1)) && (r_y == YW'(HEIGHT - 1));
  assign OVERFLOW    = r_overflow;

endmodule

// File: tb/tb_pixel_stream_unpacker.sv
// Bench for pixel_stream_unpacker: table-driven word vectors, a pixel scoreboard
// fed at stimulus time, and hand sequences for reset, latency, full-FIFO and overflow.
module tb_pixel_stream_unpacker;
  localparam int W  = 20;
  localparam int H  = 2;
  localparam int N  = 10;
  localparam int BD = 10;
  localparam int FD = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            dclk = 1'b0;
  logic            ready = 1'b0;
  logic [N*BD-1:0] dout = '0;
  logic [BD-1:0]   pix;
  logic            valid;
  logic [4:0]      px;
  logic [0:0]      py;
  logic            fs;
  logic            fe;
  logic            ovf;

  always #5 clk = ~clk;

  pixel_stream_unpacker #(
    .WIDTH(W), .HEIGHT(H), .OUTPUT_BUS_PIXEL_WIDTH(N), .BIT_DEPTH(BD), .FIFO_DEPTH(FD)
  ) dut (
    .SYSTEM_CLK(clk), .SYSTEM_RESET(rst), .DATA_OUT_CLK(dclk), .DATA_OUT(dout),
    .PIXEL_OUT(pix), .PIXEL_VALID(valid), .PIXEL_READY(ready), .PIXEL_X(px),
    .PIXEL_Y(py), .FRAME_START(fs), .FRAME_END(fe), .OVERFLOW(ovf)
  );

  typedef struct { logic [9:0] pix; logic [4:0] x; logic y; logic fs; logic fe; } exp_t;
  typedef struct { logic [9:0] base; logic [4:0] x0; logic y; logic fs; logic fe; } vec_t;

  exp_t sb[$];
  vec_t tbl[5];
  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   rdy_mode = 0;
  logic rdy_val = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*BD-1:0] mk_word(input logic [9:0] base);
    logic [N*BD-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) w[i*BD +: BD] = base + 10'(i);
    return w;
  endfunction

  task automatic push_word(input logic [9:0] base, input logic [4:0] x0, input logic y,
                           input logic f_s, input logic f_e);
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.pix = base + 10'(i);
      e.x   = x0 + 5'(i);
      e.y   = y;
      e.fs  = f_s && (i == 0);
      e.fe  = f_e && (i == N - 1);
      sb.push_back(e);
    end
  endtask

  task automatic send(input int hi, input int lo);
    dclk = 1'b1;
    repeat (hi) step();
    dclk = 1'b0;
    repeat (lo) step();
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 400 && sb.size() != 0; c++) step();
    chk({tag, "_drain_left"}, sb.size(), 0);
    step();
    step();
    chk({tag, "_idle_after_drain"}, valid, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix"}, pix, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_x"}, px, 0);
    chk({tag, "_y"}, py, 0);
    chk({tag, "_fs"}, fs, 0);
    chk({tag, "_fe"}, fe, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dclk = 1'b0;
    step();
    rst = 1'b0;
    sb.delete();
    step();
  endtask

  task automatic monitor();
    exp_t e;
    logic have_hold = 1'b0;
    logic [9:0] h_pix;
    logic [4:0] h_x;
    logic h_y, h_fs, h_fe;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_hold = 1'b0;
      end else begin
        if (have_hold) begin
          chk("stall_valid", valid, 1);
          chk("stall_pix", pix, h_pix);
          chk("stall_x", px, h_x);
          chk("stall_y", py, h_y);
          chk("stall_fs", fs, h_fs);
          chk("stall_fe", fe, h_fe);
        end
        if (valid && ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_pixel", valid & ready, 0);
          end else begin
            e = sb.pop_front();
            chk("pix", pix, e.pix);
            chk("x", px, e.x);
            chk("y", py, e.y);
            chk("frame_start", fs, e.fs);
            chk("frame_end", fe, e.fe);
            n_acc++;
          end
        end
        have_hold = valid && !ready;
        h_pix = pix; h_x = px; h_y = py; h_fs = fs; h_fe = fe;
      end
    end
  endtask

  task automatic ready_drv();
    int ph = 0;
    forever begin
      @(posedge clk);
      #2;
      ph++;
      ready = (rdy_mode != 0) ? ((ph % 4 == 0) || (ph % 4 == 3)) : rdy_val;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    tbl[0] = '{10'd0,   5'd0,  1'b0, 1'b1, 1'b0};
    tbl[1] = '{10'd100, 5'd10, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{10'd200, 5'd0,  1'b1, 1'b0, 1'b0};
    tbl[3] = '{10'd300, 5'd10, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{10'd400, 5'd0,  1'b0, 1'b1, 1'b0};
    fork
      monitor();
      ready_drv();
    join_none

    // Asynchronous reset mid-cycle, then release with the strobe already high.
    #23 rst = 1'b1;
    #1 chk_zero("por");
    dclk = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("no_strobe_after_reset", valid, 0);
    end
    dclk = 1'b0;
    step();
    step();

    // Single word: latency and ten consecutive pixels.
    rdy_val = 1'b1;
    step();
    dout = mk_word(10'd0);
    dclk = 1'b1;
    push_word(10'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("lat_after_capture_edge", valid, 0);
    step();
    chk("lat_after_pop_edge", valid, 1);
    chk("lat_lane0", pix, 0);
    dclk = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid) n++;
    end
    chk("single_word_len", n, 10);
    step();
    drain("single");

    // Full frame plus restart word, strobe period 12.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dout = mk_word(tbl[i].base);
      push_word(tbl[i].base, tbl[i].x0, tbl[i].y, tbl[i].fs, tbl[i].fe);
      send(6, 6);
    end
    drain("frame");

    // Backpressure with ready pattern 1,0,0,1.
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 4; i++) begin
      dout = mk_word(tbl[i].base);
      push_word(tbl[i].base, tbl[i].x0, tbl[i].y, tbl[i].fs, tbl[i].fe);
      send(6, 6);
    end
    drain("backpressure");
    rdy_mode = 0;

    // Full FIFO: strobe coincides with the last-lane pop, write must land.
    do_reset();
    rdy_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dout = mk_word(tbl[i].base);
      push_word(tbl[i].base, tbl[i].x0, tbl[i].y, tbl[i].fs, tbl[i].fe);
      send(2, 2);
    end
    chk("full_no_ovf_yet", ovf, 0);
    rdy_val = 1'b1;
    repeat (9) step();
    dout = mk_word(10'd500);
    push_word(10'd500, 5'd10, 1'b0, 1'b0, 1'b0);
    dclk = 1'b1;
    step();
    step();
    dclk = 1'b0;
    step();
    chk("full_pop_same_cycle_no_ovf", ovf, 0);
    drain("fullpop");

    // Overflow: sixth strobe with FIFO full and consumer stalled is dropped.
    do_reset();
    rdy_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dout = mk_word(tbl[i].base);
      push_word(tbl[i].base, tbl[i].x0, tbl[i].y, tbl[i].fs, tbl[i].fe);
      send(2, 2);
    end
    chk("ovf_after_5", ovf, 0);
    dout = mk_word(10'd700);
    send(2, 2);
    chk("ovf_after_6", ovf, 1);
    rdy_val = 1'b1;
    drain("ovf");
    dout = mk_word(10'd600);
    push_word(10'd600, 5'd0, 1'b1, 1'b0, 1'b0);
    send(6, 6);
    drain("ovf_realign");
    chk("ovf_sticky", ovf, 1);

    // Reset after three of ten pixels.
    do_reset();
    chk("ovf_cleared_by_reset", ovf, 0);
    base = n_acc;
    dout = mk_word(10'd800);
    push_word(10'd800, 5'd0, 1'b0, 1'b1, 1'b0);
    dclk = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      if (n_acc - base >= 3) break;
    end
    chk("midword_three_taken", n_acc - base, 3);
    #1 rst = 1'b1;
    #1 chk_zero("midword_reset");
    sb.delete();
    dclk = 1'b0;
    step();
    rst = 1'b0;
    step();
    dout = mk_word(10'd900);
    push_word(10'd900, 5'd0, 1'b0, 1'b1, 1'b0);
    send(6, 6);
    drain("after_midword");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
